fp_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one fp_mult instance between NUM_REQ requesters, each using a valid/ready handshake.
- Grants one requester at a time and drives the operands and rounding mode into the multiplier.
- Holds those operands stable for the whole multiplier pipeline, because the exception stage reads a/b combinationally in the output cycle.
- Captures z/status and returns them to the granted requester over a per-requester response handshake.

---
 rtl/fp_mult_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
//   Shares one fp_mult instance between NUM_REQ requesters. One requester is
//   granted at a time. Its operands are latched and held on mult_a/mult_b/
//   mult_rnd for the whole multiplier pipeline, because fp_mult's exception
//   stage reads a/b combinationally in its output cycle. The result is then
//   returned to that requester over a per-requester response handshake.
//
//   Build option: FP_MULT_ARB_FIXED_PRIO_EN
//     undefined : round-robin arbitration starting at rr_ptr.
//     defined   : fixed priority (lowest index wins), no rr_ptr, and an extra
//                 starve_flag output.
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     req_valid/req_ready per-requester request handshake (ready one-hot/zero)
//     req_a/req_b/req_rnd packed operands, requester i at [32i+31:32i] / [3i+2:3i]
//     resp_valid/ready    per-requester result handshake (valid one-hot/zero)
//     resp_z/resp_status  shared result bus, held while resp_valid is high
//     grant_idx           current or last granted requester
//     busy                high whenever the sequencer is not idle
//     mult_a/b/rnd        operands to fp_mult
//     mult_z/mult_status  result from fp_mult
//     starve_flag         (fixed priority only) some requester has waited
//                         through 16 or more grants to others
//
//   state | meaning
//   IDLE  | arbitrate; winner is accepted on this edge
//   EXEC  | operands held on fp_mult; cnt counts pipeline cycles
//   RESP  | result presented to grant_idx until it is accepted

module fp_mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 1,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]   req_rnd,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            resp_z,
    output logic [7:0]             resp_status,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic [31:0]            mult_a,
    output logic [31:0]            mult_b,
    output logic [2:0]             mult_rnd,
    input  logic [31:0]            mult_z,
    input  logic [7:0]             mult_status
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    ,
    output logic                   starve_flag
`endif
);

    localparam int CNT_W = (MULT_LAT < 1) ? 1 : $clog2(MULT_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [2:0]       op_rnd;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             accept;
    logic             resp_done;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = |req_valid;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win_idx = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   rot_off;
    logic [IDX_W:0]     rot_sum;

    // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set
    // bit, then rotate the offset back into an absolute index.
    always_comb begin
        rot       = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        win_found = |req_valid;
        rot_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) rot_off = IDX_W'(i);
        end
        rot_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
        if (rot_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            rot_sum = rot_sum - (IDX_W + 1)'(NUM_REQ);
        end
        win_idx = rot_sum[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (resp_done) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign accept    = (state == ST_IDLE) && win_found;
    assign resp_done = (state == ST_RESP) && resp_ready[grant_idx];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready = NUM_REQ'(1) << win_idx;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == CNT_LAST) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = NUM_REQ'(1) << grant_idx;
                if (resp_ready[grant_idx]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand and result registers. Operands only change on an accept, so
    // fp_mult sees them unchanged through EXEC and they linger afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx   <= '0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_rnd      <= '0;
            resp_z      <= '0;
            resp_status <= '0;
        end else begin
            if (accept) begin
                op_a      <= req_a[int'(win_idx) * 32 +: 32];
                op_b      <= req_b[int'(win_idx) * 32 +: 32];
                op_rnd    <= req_rnd[int'(win_idx) * 3 +: 3];
                grant_idx <= win_idx;
                cnt       <= '0;
            end
            if (state == ST_EXEC) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    resp_z      <= mult_z;
                    resp_status <= mult_status;
                end
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign mult_a   = op_a;
    assign mult_b   = op_b;
    assign mult_rnd = op_rnd;

`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    // Per-requester count of grants to others while continuously waiting.
    // Saturates at 16; bit 4 is the starvation indication.
    logic [4:0] starve_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    starve_cnt[i] <= '0;
                end else if (accept) begin
                    if (win_idx == IDX_W'(i))   starve_cnt[i] <= '0;
                    else if (!starve_cnt[i][4]) starve_cnt[i] <= starve_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        starve_flag = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (starve_cnt[i][4]) starve_flag = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Testbench for fp_mult_arbiter. A stand-in fp_mult (MULT_LAT register
// stages for z, combinational status from the live operands) is built from
// a real-arithmetic reference multiply; arbitration order is predicted from
// the round-robin / fixed-priority rules directly.
module tb_fp_mult_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = 1;
    localparam int IDX_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [3*NUM_REQ-1:0]  req_rnd = '0;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready = '0;
    logic [31:0]           resp_z;
    logic [7:0]            resp_status;
    logic [IDX_W-1:0]      grant_idx;
    logic                  busy;
    logic [31:0]           mult_a;
    logic [31:0]           mult_b;
    logic [2:0]            mult_rnd;
    logic [31:0]           mult_z;
    logic [7:0]            mult_status;
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    logic                  starve_flag;
`endif

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    fp_mult_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(MULT_LAT), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_z(resp_z), .resp_status(resp_status),
        .grant_idx(grant_idx), .busy(busy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_rnd(mult_rnd),
        .mult_z(mult_z), .mult_status(mult_status)
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
        , .starve_flag(starve_flag)
`endif
    );

    // Reference multiply: {status, z}; status = {rnd, uf, of, nan, 2'b0}.
    function automatic logic [39:0] fmul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rnd);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic [31:0] z;
        logic [4:0]  fl;
        logic [63:0] pb;
        real         ra, rb;
        int          e;
        s = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
        fl = 5'b0;
        if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
            (ea == 8'hFF && b[30:0] == 0) || (eb == 8'hFF && a[30:0] == 0)) begin
            z = 32'h7FC00000; fl = 5'b00100;
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            z = {s, 8'hFF, 23'd0};
        end else if (ea == 8'h00 || eb == 8'h00) begin
            z = {s, 31'd0};
        end else begin
            ra = $bitstoreal({1'b0, {3'b000, ea} + 11'd896, ma, 29'd0});
            rb = $bitstoreal({1'b0, {3'b000, eb} + 11'd896, mb, 29'd0});
            pb = $realtobits(ra * rb);
            e  = int'(pb[62:52]) - 896;
            if (e >= 255)    begin z = {s, 8'hFF, 23'd0}; fl = 5'b01000; end
            else if (e <= 0) begin z = {s, 31'd0};        fl = 5'b10000; end
            else             z = {s, e[7:0], pb[51:29]};
        end
        return {rnd, fl, z};
    endfunction

    // Stand-in fp_mult.
    logic [31:0] st_a   [MULT_LAT];
    logic [31:0] st_b   [MULT_LAT];
    logic [2:0]  st_rnd [MULT_LAT];
    logic [39:0] z_full, s_full;

    always @(posedge clk) begin
        st_a[0] <= mult_a; st_b[0] <= mult_b; st_rnd[0] <= mult_rnd;
        for (int i = 1; i < MULT_LAT; i++) begin
            st_a[i] <= st_a[i-1]; st_b[i] <= st_b[i-1]; st_rnd[i] <= st_rnd[i-1];
        end
    end
    assign z_full      = fmul(st_a[MULT_LAT-1], st_b[MULT_LAT-1], st_rnd[MULT_LAT-1]);
    assign s_full      = fmul(mult_a, mult_b, mult_rnd);
    assign mult_z      = z_full[31:0];
    assign mult_status = s_full[39:32];

    function automatic int model_winner(input logic [NUM_REQ-1:0] m);
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (m[i]) return i;
`else
        for (int k = 0; k < NUM_REQ; k++)
            if (m[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
`endif
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] r);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rnd[3*i +: 3] = r;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready !== '0) begin ok = 1'b1; return; end
            step();
        end
    endtask

    task automatic wait_resp(output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid !== '0) begin ok = 1'b1; return; end
            step();
            lat++;
        end
    endtask

    task automatic apply_reset();
        req_valid = '0; resp_ready = '0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_ptr = 0;
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++;
        if ({req_ready, resp_valid, busy, grant_idx, mult_rnd} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%h rv=%h busy=%b gi=%0d rnd=%0d want all 0",
                     req_ready, resp_valid, busy, grant_idx, mult_rnd);
        end
        checks++;
        if ({mult_a, mult_b} !== 64'd0) begin
            errors++; $display("FAIL reset_mult_ops got %h %h want 0 0", mult_a, mult_b);
        end
        checks++;
        if ({resp_z, resp_status} !== 40'd0) begin
            errors++; $display("FAIL reset_resp got %h %h want 0 0", resp_z, resp_status);
        end
        step();
        rst = 1'b1;
        model_ptr = 0;
        step();
    endtask

    task automatic test_single_op();
        int lat; bit ok;
        set_op(0, 32'h3FC00000, 32'h40000000, 3'd0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_req_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        wait_resp(lat, ok);
        checks++;
        if (!ok || lat != MULT_LAT + 1) begin
            errors++; $display("FAIL single_latency got %0d (seen=%0d) want %0d", lat, ok, MULT_LAT + 1);
        end
        checks++;
        if (resp_valid !== 4'b0001) begin
            errors++; $display("FAIL single_resp_valid got %b want 0001", resp_valid);
        end
        checks++;
        if (resp_z !== 32'h40400000 || resp_status !== 8'h00) begin
            errors++; $display("FAIL single_result got %h/%h want 40400000/00", resp_z, resp_status);
        end
        resp_ready = 4'b0001;
        step();
        resp_ready = '0;
        model_ptr = 1;
        checks++;
        if (resp_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done got rv=%b busy=%b want 0000 0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int w, lat; bit ok;
        logic [39:0] ex;
        logic [NUM_REQ-1:0] oh;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
        req_valid = '1; resp_ready = '1;
        for (int g = 0; g < 5; g++) begin
            wait_ready(ok);
            w = model_winner(req_valid);
            oh = NUM_REQ'(1) << w;
            checks++;
            if (!ok || req_ready !== oh) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", g, req_ready, oh);
            end
            ex = fmul(req_a[32*w +: 32], req_b[32*w +: 32], req_rnd[3*w +: 3]);
            step();
            set_op(w, $urandom, $urandom, 3'($urandom_range(0, 7)));
            wait_resp(lat, ok);
            checks++;
            if (!ok || grant_idx !== IDX_W'(w) || resp_z !== ex[31:0]) begin
                errors++; $display("FAIL rr_result%0d got gi=%0d z=%h want gi=%0d z=%h",
                                   g, grant_idx, resp_z, w, ex[31:0]);
            end
            step();
            model_ptr = (w + 1) % NUM_REQ;
        end
        req_valid = '0; resp_ready = '0;
    endtask

    task automatic test_back_pressure();
        int w, lat; bit ok;
        logic [39:0] ex;
        logic [NUM_REQ-1:0] oh;
        set_op(1, $urandom, $urandom, 3'd5);
        req_valid = 4'b0010;
        wait_ready(ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant got %b want 0010", req_ready);
        end
        ex = fmul(req_a[63:32], req_b[63:32], 3'd5);
        step();
        req_valid = 4'b1101; resp_ready = 4'b1101;
        wait_resp(lat, ok);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (!ok || resp_valid !== 4'b0010 || resp_z !== ex[31:0] || resp_status !== ex[39:32]
                || req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got rv=%b z=%h st=%h rdy=%b busy=%b want 0010 %h %h 0000 1",
                         c, resp_valid, resp_z, resp_status, req_ready, busy, ex[31:0], ex[39:32]);
            end
            step();
        end
        resp_ready = '1;
        step();
        resp_ready = '0;
        model_ptr = 2;
        #1;
        w = model_winner(req_valid);
        oh = NUM_REQ'(1) << w;
        checks++;
        if (resp_valid !== '0 || busy !== 1'b0 || req_ready !== oh) begin
            errors++; $display("FAIL bp_release got rv=%b busy=%b rdy=%b want 0000 0 %b",
                               resp_valid, busy, req_ready, oh);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_operand_stability();
        int w, lat; bit ok;
        logic [NUM_REQ-1:0] oh;
        set_op(2, 32'h7F800000, 32'h00000000, 3'd0);
        req_valid = 4'b0100;
        wait_ready(ok);
        w = model_winner(req_valid);
        oh = NUM_REQ'(1) << w;
        checks++;
        if (!ok || req_ready !== oh) begin
            errors++; $display("FAIL stab_grant got %b want %b", req_ready, oh);
        end
        step();
        req_valid = '0;
        set_op(2, $urandom, $urandom, 3'd3);
        for (int c = 0; c <= MULT_LAT; c++) begin
            checks++;
            if (mult_a !== 32'h7F800000 || mult_b !== 32'h0 || resp_valid !== '0) begin
                errors++; $display("FAIL stab_exec%0d got a=%h b=%h rv=%b want 7f800000 0 0000",
                                   c, mult_a, mult_b, resp_valid);
            end
            step();
        end
        checks++;
        if (resp_valid !== 4'b0100 || resp_status[2] !== 1'b1 || resp_z[30:23] !== 8'hFF
            || resp_z[22:0] === 23'd0 || mult_a !== 32'h7F800000) begin
            errors++; $display("FAIL stab_nan got rv=%b z=%h st=%h a=%h want 0100 NaN nan_f a=7f800000",
                               resp_valid, resp_z, resp_status, mult_a);
        end
        resp_ready = 4'b0100;
        step();
        resp_ready = '0;
        model_ptr = 3;
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        set_op(3, $urandom | 32'h0080_0000, $urandom, 3'd1);
        req_valid = 4'b1000;
        wait_ready(ok);
        step();
        req_valid = '0;
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++; $display("FAIL rst_exec_entry got busy=%b want 1", busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, grant_idx, mult_rnd, mult_a, mult_b, resp_z, resp_status} !== '0) begin
            errors++; $display("FAIL rst_exec_clear got busy=%b gi=%0d a=%h b=%h z=%h want all 0",
                               busy, grant_idx, mult_a, mult_b, resp_z);
        end
        step();
        rst = 1'b1;
        model_ptr = 0;
        for (int c = 0; c < MULT_LAT + 4; c++) begin
            checks++;
            if (resp_valid !== '0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_exec_quiet%0d got rv=%b busy=%b want 0000 0", c, resp_valid, busy);
            end
            step();
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rst_exec_restart got %b want 0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        int w, lat, hold; bit ok;
        logic [39:0] ex;
        logic [NUM_REQ-1:0] m, oh;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
            m = NUM_REQ'($urandom_range(0, 15));
            req_valid = m;
            #1;
            if (m == '0) begin
                checks++;
                if (req_ready !== '0 || busy !== 1'b0) begin
                    errors++; $display("FAIL rnd_idle%0d got rdy=%b busy=%b want 0000 0", it, req_ready, busy);
                end
                step();
                continue;
            end
            w = model_winner(m);
            oh = NUM_REQ'(1) << w;
            checks++;
            if (req_ready !== oh) begin
                errors++; $display("FAIL rnd_grant%0d got %b want %b (valid %b)", it, req_ready, oh, m);
            end
            ex = fmul(req_a[32*w +: 32], req_b[32*w +: 32], req_rnd[3*w +: 3]);
            step();
            req_valid = NUM_REQ'($urandom_range(0, 15));
            set_op(w, $urandom, $urandom, 3'($urandom_range(0, 7)));
            wait_resp(lat, ok);
            checks++;
            if (!ok || lat != MULT_LAT + 1 || resp_valid !== oh || grant_idx !== IDX_W'(w)
                || resp_z !== ex[31:0] || resp_status !== ex[39:32]) begin
                errors++;
                $display("FAIL rnd_resp%0d got lat=%0d rv=%b gi=%0d z=%h st=%h want %0d %b %0d %h %h",
                         it, lat, resp_valid, grant_idx, resp_z, resp_status,
                         MULT_LAT + 1, oh, w, ex[31:0], ex[39:32]);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                resp_ready = NUM_REQ'($urandom_range(0, 15)) & ~oh;
                step();
                checks++;
                if (resp_valid !== oh || resp_z !== ex[31:0]) begin
                    errors++; $display("FAIL rnd_hold%0d got rv=%b z=%h want %b %h", it, resp_valid, resp_z, oh, ex[31:0]);
                end
            end
            resp_ready = oh | NUM_REQ'($urandom_range(0, 15));
            step();
            resp_ready = '0;
            model_ptr = (w + 1) % NUM_REQ;
        end
        req_valid = '0;
        step();
    endtask

`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    task automatic test_starvation();
        int lat; bit ok;
        apply_reset();
        req_valid = 4'b1001;
        resp_ready = 4'b0001;
        for (int g = 0; g < 16; g++) begin
            wait_ready(ok);
            checks++;
            if (!ok || req_ready !== 4'b0001 || starve_flag !== 1'b0) begin
                errors++; $display("FAIL starve_pre%0d got rdy=%b flag=%b want 0001 0", g, req_ready, starve_flag);
            end
            step();
            wait_resp(lat, ok);
            step();
        end
        #1;
        checks++;
        if (starve_flag !== 1'b1) begin
            errors++; $display("FAIL starve_set got %b want 1", starve_flag);
        end
        req_valid = 4'b1000;
        resp_ready = 4'b1000;
        wait_ready(ok);
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++; $display("FAIL starve_grant3 got %b want 1000", req_ready);
        end
        step();
        checks++;
        if (starve_flag !== 1'b0) begin
            errors++; $display("FAIL starve_clear got %b want 0", starve_flag);
        end
        req_valid = '0;
        wait_resp(lat, ok);
        step();
        resp_ready = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_operand_stability();
        test_reset_mid_exec();
        test_random();
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
        test_starvation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
